// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache memory-port arbiter.
// Imported by the arbiter top and its request holding register.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_FLUSH   = 2'd3
    } arb_state_e;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [3:0] MEM_SEL_ALL   = 4'b1111;

endpackage

// File: rtl/cache_mem_arbiter_arb_req_reg.sv
// Holding register for the granted memory request.
// Loaded on grant, held until the next grant, cleared on reset.
module arb_req_reg
    import cache_mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic          write_i,
    input  logic [1:0]    size_i,
    input  logic [3:0]    sel_i,
    input  logic [DW-1:0] data_i,
    output logic [AW-1:0] addr_o,
    output logic          write_o,
    output logic [1:0]    size_o,
    output logic [3:0]    sel_o,
    output logic [DW-1:0] data_o
);

    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic [3:0]    sel_q;
    logic [DW-1:0] data_q;

    // Capture the winning request; hold it for the whole transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            addr_q  <= addr_i;
            write_q <= write_i;
            size_q  <= size_i;
            sel_q   <= sel_i;
            data_q  <= data_i;
        end
    end

    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign size_o  = size_q;
    assign sel_o   = sel_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter for the single AXI memory port between i-cache and d-cache.
// Registered grant, flush cancel, bounded data bursts vs. fetch.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int D_BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          i_strobe,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_strobe,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_size,
    input  logic [3:0]    d_sel,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_access,
    output logic [AW-1:0] mem_a,
    output logic          mem_write,
    output logic [1:0]    mem_size,
    output logic [3:0]    mem_sel,
    output logic [DW-1:0] mem_st_data,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_data
);

    localparam int BW = $clog2(D_BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(D_BURST_MAX);

    arb_state_e    state_q;
    logic          access_q;
    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_d;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic          idle;
    logic          d_wins;
    logic          grant_i;
    logic          grant_d;
    logic          i_done;
    logic          d_done;

    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [1:0]    req_size;
    logic [3:0]    req_sel;
    logic [DW-1:0] req_data;

    assign idle   = (state_q == ARB_IDLE);
    assign d_wins = d_strobe & (~i_strobe | (burst_q < BURST_MAX));
    assign grant_d = idle & ~flush & d_wins;
    assign grant_i = idle & ~flush & i_strobe & ~d_wins;

    assign i_done = (state_q == ARB_GRANT_I) & mem_ready;
    assign d_done = (state_q == ARB_GRANT_D) & mem_ready;

    // Fetch is always a full-word read; data side passes through.
    assign req_addr  = grant_i ? i_addr        : d_addr;
    assign req_write = grant_i ? 1'b0          : d_rw;
    assign req_size  = grant_i ? MEM_SIZE_WORD : d_size;
    assign req_sel   = grant_i ? MEM_SEL_ALL   : d_sel;
    assign req_data  = grant_i ? '0            : d_wdata;

    arb_req_reg #(
        .AW (AW),
        .DW (DW)
    ) u_req (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (grant_i | grant_d),
        .addr_i  (req_addr),
        .write_i (req_write),
        .size_i  (req_size),
        .sel_i   (req_sel),
        .data_i  (req_data),
        .addr_o  (mem_a),
        .write_o (mem_write),
        .size_o  (mem_size),
        .sel_o   (mem_sel),
        .data_o  (mem_st_data)
    );

    // Arbitration FSM; mem_access is registered alongside the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ARB_IDLE;
            access_q <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state_q  <= ARB_GRANT_I;
                        access_q <= 1'b1;
                    end else if (grant_d) begin
                        state_q  <= ARB_GRANT_D;
                        access_q <= 1'b1;
                    end
                end
                ARB_GRANT_I,
                ARB_GRANT_D: begin
                    if (mem_ready) begin
                        state_q  <= ARB_IDLE;
                        access_q <= 1'b0;
                    end else if (flush) begin
                        state_q  <= ARB_FLUSH;
                        access_q <= 1'b0;
                    end
                end
                ARB_FLUSH: begin
                    state_q  <= ARB_IDLE;
                    access_q <= 1'b0;
                end
                default: begin
                    state_q  <= ARB_IDLE;
                    access_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch-starvation counter: data wins while below the bound.
    always_comb begin
        burst_d = burst_q;
        if (i_done) begin
            burst_d = '0;
        end else if (d_done && i_strobe && burst_q != BURST_MAX) begin
            burst_d = burst_q + 1'b1;
        end else if (idle && !i_strobe) begin
            burst_d = '0;
        end
    end

    // Burst counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    // Keep the last returned word for each requester.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_done) i_rdata_q <= mem_data;
            if (d_done) d_rdata_q <= mem_data;
        end
    end

    assign mem_access = access_q;
    assign i_ready    = i_done;
    assign d_ready    = d_done;
    assign i_rdata    = i_done ? mem_data : i_rdata_q;
    assign d_rdata    = d_done ? mem_data : d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter.
// Vector table for basic traffic, directed sequences for corner cases.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        i_strobe;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_strobe;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_access;
    logic [31:0] mem_a;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    cache_mem_arbiter #(
        .AW          (32),
        .DW          (32),
        .D_BURST_MAX (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .i_strobe    (i_strobe),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .i_rdata     (i_rdata),
        .d_strobe    (d_strobe),
        .d_rw        (d_rw),
        .d_addr      (d_addr),
        .d_size      (d_size),
        .d_sel       (d_sel),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .mem_access  (mem_access),
        .mem_a       (mem_a),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_sel     (mem_sel),
        .mem_st_data (mem_st_data),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_ready && d_ready) viol++;
    end

    typedef struct {
        logic        fl;
        logic        is;
        logic        ds;
        logic        rw;
        logic        mr;
        logic [31:0] md;
        logic        ea;
        logic        eir;
        logic        edr;
        logic        ew;
        logic [1:0]  esz;
        logic [3:0]  esel;
        logic [31:0] eaddr;
        logic [31:0] est;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h1FAF_0000;
    localparam logic [31:0] WD = 32'h0000_A5A5;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, check its kind, then complete it next cycle.
    task automatic serve(input logic exp_d, input logic [31:0] md,
                         input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_access && n < 20) begin
            cyc();
            @(negedge clk);
            n++;
        end
        chk({nm, " grant_seen"}, 32'(n < 20), 32'd1);
        chk({nm, " mem_write"}, 32'(mem_write), 32'(exp_d));
        chk({nm, " mem_sel"}, 32'(mem_sel),
            exp_d ? 32'h3 : 32'hF);
        cyc();
        mem_ready = 1'b1;
        mem_data  = md;
        @(negedge clk);
        chk({nm, " i_ready"}, 32'(i_ready), 32'(!exp_d));
        chk({nm, " d_ready"}, 32'(d_ready), 32'(exp_d));
        cyc();
        mem_ready = 1'b0;
    endtask

    initial begin
        logic exp_kind[10];

        // fl is ds rw mr md | ea ir dr w sz sel addr st ird drd
        vecs[0]  = '{0,1,0,0,0,0,            0,0,0,0,0,4'h0,0, 0, 0,0};
        vecs[1]  = '{0,1,0,0,0,0,            1,0,0,0,2,4'hF,IA,0, 0,0};
        vecs[2]  = '{0,0,0,0,0,0,            1,0,0,0,2,4'hF,IA,0, 0,0};
        vecs[3]  = '{0,0,0,0,0,0,            1,0,0,0,2,4'hF,IA,0, 0,0};
        vecs[4]  = '{0,0,0,0,1,32'h3C1D0001, 1,1,0,0,2,4'hF,IA,0,
                     32'h3C1D0001,0};
        vecs[5]  = '{0,0,0,0,0,0,            0,0,0,0,2,4'hF,IA,0,
                     32'h3C1D0001,0};
        vecs[6]  = '{0,1,1,1,0,0,            0,0,0,0,2,4'hF,IA,0,
                     32'h3C1D0001,0};
        vecs[7]  = '{0,1,1,1,0,0,            1,0,0,1,1,4'h3,DA,WD,
                     32'h3C1D0001,0};
        vecs[8]  = '{0,1,1,1,1,32'h12345678, 1,0,1,1,1,4'h3,DA,WD,
                     32'h3C1D0001,32'h12345678};
        vecs[9]  = '{0,1,0,1,0,0,            0,0,0,1,1,4'h3,DA,WD,
                     32'h3C1D0001,32'h12345678};
        vecs[10] = '{0,1,0,1,0,0,            1,0,0,0,2,4'hF,IA,0,
                     32'h3C1D0001,32'h12345678};
        vecs[11] = '{0,1,0,1,1,32'hCAFEF00D, 1,1,0,0,2,4'hF,IA,0,
                     32'hCAFEF00D,32'h12345678};
        vecs[12] = '{0,0,0,1,0,0,            0,0,0,0,2,4'hF,IA,0,
                     32'hCAFEF00D,32'h12345678};

        resetn    = 1'b0;
        flush     = 1'b0;
        i_strobe  = 1'b0;
        i_addr    = IA;
        d_strobe  = 1'b0;
        d_rw      = 1'b0;
        d_addr    = DA;
        d_size    = 2'b01;
        d_sel     = 4'b0011;
        d_wdata   = WD;
        mem_ready = 1'b0;
        mem_data  = '0;

        repeat (3) @(negedge clk);
        chk("rst mem_access", 32'(mem_access), 0);
        chk("rst mem_a", mem_a, 0);
        chk("rst mem_sel", 32'(mem_sel), 0);
        chk("rst mem_size", 32'(mem_size), 0);
        chk("rst i_rdata", i_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        resetn = 1'b1;
        cyc();

        // Table: I-only read, then simultaneous D-store/I-read.
        for (int k = 0; k < 13; k++) begin
            flush     = vecs[k].fl;
            i_strobe  = vecs[k].is;
            d_strobe  = vecs[k].ds;
            d_rw      = vecs[k].rw;
            mem_ready = vecs[k].mr;
            mem_data  = vecs[k].md;
            @(negedge clk);
            chk($sformatf("v%0d mem_access", k), 32'(mem_access),
                32'(vecs[k].ea));
            chk($sformatf("v%0d i_ready", k), 32'(i_ready),
                32'(vecs[k].eir));
            chk($sformatf("v%0d d_ready", k), 32'(d_ready),
                32'(vecs[k].edr));
            chk($sformatf("v%0d mem_write", k), 32'(mem_write),
                32'(vecs[k].ew));
            chk($sformatf("v%0d mem_size", k), 32'(mem_size),
                32'(vecs[k].esz));
            chk($sformatf("v%0d mem_sel", k), 32'(mem_sel),
                32'(vecs[k].esel));
            chk($sformatf("v%0d mem_a", k), mem_a, vecs[k].eaddr);
            chk($sformatf("v%0d mem_st_data", k), mem_st_data,
                vecs[k].est);
            chk($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].eird);
            chk($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].edrd);
            cyc();
        end
        mem_ready = 1'b0;

        // Starvation bound: 4 D, I, then counter restarts at 0.
        for (int k = 0; k < 10; k++) exp_kind[k] = (k != 4 && k != 9);
        i_strobe = 1'b1;
        d_strobe = 1'b1;
        d_rw     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            serve(exp_kind[k], 32'(k), $sformatf("burst%0d", k));
        end
        i_strobe = 1'b0;
        d_strobe = 1'b0;
        cyc();
        cyc();

        // Flush mid D-load: no d_ready, FLUSH then IDLE.
        d_strobe = 1'b1;
        d_rw     = 1'b0;
        cyc();
        d_strobe = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk("fl granted", 32'(mem_access), 1);
        chk("fl d_ready0", 32'(d_ready), 0);
        cyc();
        flush    = 1'b0;
        i_strobe = 1'b1;
        @(negedge clk);
        chk("fl access_drop", 32'(mem_access), 0);
        chk("fl d_ready1", 32'(d_ready), 0);
        cyc();
        @(negedge clk);
        chk("fl idle_gap", 32'(mem_access), 0);
        cyc();
        @(negedge clk);
        chk("fl i_grant", 32'(mem_access), 1);
        chk("fl i_sel", 32'(mem_sel), 32'hF);
        i_strobe  = 1'b0;
        cyc();
        mem_ready = 1'b1;
        mem_data  = 32'h0BAD_F00D;
        @(negedge clk);
        chk("fl i_ready", 32'(i_ready), 1);
        chk("fl d_rdata_keep", d_rdata, 32'd8);
        cyc();
        mem_ready = 1'b0;

        // Flush coincident with mem_ready: completion wins.
        i_strobe = 1'b1;
        cyc();
        i_strobe  = 1'b0;
        flush     = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 32'h1111_2222;
        @(negedge clk);
        chk("flr i_ready", 32'(i_ready), 1);
        chk("flr i_rdata", i_rdata, 32'h1111_2222);
        cyc();
        flush     = 1'b0;
        mem_ready = 1'b0;
        i_strobe  = 1'b1;
        @(negedge clk);
        chk("flr access_low", 32'(mem_access), 0);
        chk("flr i_ready_once", 32'(i_ready), 0);
        cyc();
        i_strobe = 1'b0;
        @(negedge clk);
        chk("flr no_flush_state", 32'(mem_access), 1);
        cyc();
        mem_ready = 1'b1;
        mem_data  = 32'h3333_4444;
        @(negedge clk);
        chk("flr i_ready2", 32'(i_ready), 1);
        cyc();
        mem_ready = 1'b0;

        // Async reset during GRANT_D.
        d_strobe = 1'b1;
        d_rw     = 1'b1;
        cyc();
        d_strobe = 1'b0;
        @(negedge clk);
        chk("rstm granted", 32'(mem_access), 1);
        #1;
        resetn    = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rstm mem_access", 32'(mem_access), 0);
        chk("rstm mem_sel", 32'(mem_sel), 0);
        chk("rstm mem_write", 32'(mem_write), 0);
        chk("rstm d_ready", 32'(d_ready), 0);
        chk("rstm d_rdata", d_rdata, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        resetn    = 1'b1;
        cyc();
        i_strobe = 1'b1;
        serve(1'b0, 32'h5555_6666, "rstm after");
        i_strobe = 1'b0;
        @(negedge clk);
        chk("rstm i_rdata", i_rdata, 32'h5555_6666);

        chk("ready exclusive", 32'(viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the single memory port of axi_interface between the i-cache miss path and the d-cache miss/uncached path.
- Replaces the combinational sel_i mux in mycpu_top.
- Latches the winning request and holds address, size, strobe and data stable until mem_ready.
- Returns data and a ready pulse to the winner only; handles exception flush and bounds starvation of instruction fetch.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- D_BURST_MAX, 4, consecutive data grants allowed while an instruction request waits.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low (clk/resetn, as in axi_interface)
- flush  in  1  exception flush (|excepttypeM)
- i_strobe  in  1  i-cache memory request (m_fetch)
- i_addr  in  AW  i-cache line/word address (m_i_a)
- i_ready  out  1  one-cycle completion pulse to i-cache
- i_rdata  out  DW  read data to i-cache
- d_strobe  in  1  d-cache memory request (m_ld_st)
- d_rw  in  1  1 = store, 0 = load
- d_addr  in  AW  d-cache address (m_d_a)
- d_size  in  2  transfer size
- d_sel  in  4  byte enables
- d_wdata  in  DW  store data
- d_ready  out  1  one-cycle completion pulse to d-cache
- d_rdata  out  DW  read data to d-cache
- mem_access  out  1  request to axi_interface
- mem_a  out  AW  address
- mem_write  out  1  write enable
- mem_size  out  2  size
- mem_sel  out  4  byte strobes
- mem_st_data  out  DW  store data
- mem_ready  in  1  transfer complete (single-cycle pulse)
- mem_data  in  DW  read data

Behaviour:
- State machine: IDLE, GRANT_I, GRANT_D, FLUSH. Reset sends the state to IDLE.
- Reset values: all mem_* outputs 0, i_ready = d_ready = 0, i_rdata = d_rdata = 0, burst counter 0.
- IDLE arbitration (evaluated every cycle):
  - d_strobe & i_strobe: D wins if burst_cnt < D_BURST_MAX, otherwise I wins.
  - Only one strobe asserted: that requester wins.
  - flush & ~busy: no grant this cycle.
- On grant, in the same clock edge:
  - Latch the request into the mem_* registers. mem_access=1 from the next cycle.
  - I grant drives mem_write=0, mem_size=2'b10, mem_sel=4'b1111, mem_st_data=0.
  - D grant drives mem_write=d_rw, mem_size=d_size, mem_sel=d_sel, mem_st_data=d_wdata.
- Latency: strobe sampled in cycle N → mem_access high in cycle N+1. Minimum one idle cycle between grants.
- GRANT_x: mem_* held constant (the registered copy) until mem_ready.
- On mem_ready in GRANT_x:
  - x_ready is a combinational pulse in the same cycle; x_rdata = mem_data, registered-hold thereafter.
  - mem_access drops at the next edge; return to IDLE.
- Burst counter:
  - A D completion while i_strobe is high increments it, saturating at D_BURST_MAX.
  - An I completion, or any cycle in IDLE with i_strobe low, clears it to 0.
- Flush:
  - flush in GRANT_x without mem_ready → FLUSH. mem_access drops at the next edge (axi_interface cancels internally). No x_ready is ever issued for the flushed request.
  - flush and mem_ready in the same cycle: the completion wins (x_ready issued), then IDLE.
  - FLUSH lasts exactly one cycle with mem_access=0, then IDLE. Requests are not sampled during FLUSH.
- A requester that drops its strobe while granted is ignored; the transfer runs to completion and the ready pulse is still issued.
- The wrong requester never sees ready: i_ready & d_ready is never true.
- resetn low mid-transfer: immediate IDLE, all outputs to reset values asynchronously.

Decomposition:
- Shared package / defines.h additions:
  - State encodings ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D, ARB_FLUSH (2 bits).
  - Constant MEM_SIZE_WORD = 2'b10.
  - Constant MEM_SEL_ALL = 4'b1111.
- One natural sub-module: arb_req_reg, the granted-request holding register (addr/size/sel/data/write, load on grant, clear on reset).

Test Plan:
- I-only read: i_strobe, i_addr=0xBFC00000; mem_ready 3 cycles after mem_access with mem_data=0x3C1D0001 → one i_ready pulse, i_rdata=0x3C1D0001, d_ready never high.
- Simultaneous requests: i_strobe and d_strobe (d_rw=1, d_addr=0x1FAF0000, d_sel=4'b0011, d_wdata=0xA5A5) → D served first with mem_write=1 and mem_sel=4'b0011; I served next with mem_sel=4'b1111.
- Starvation bound: d_strobe held continuously with i_strobe high, D_BURST_MAX=4 → exactly 4 D transfers, then an I grant, then the counter is 0.
- Flush mid-D-load: flush 1 cycle after grant, no mem_ready → FLUSH state, mem_access low the next cycle, no d_ready; a new i_strobe is granted 2 cycles after flush.
- Flush coincident with mem_ready during GRANT_I → i_ready pulses, return to IDLE, no FLUSH state.
- resetn asserted low during GRANT_D → mem_access=0 and state IDLE immediately; after release, a new request is served normally.
